// File: rtl/c123_scr_mmr.sv
// C123 tilemap control-register file: 32 CPU-visible bytes decoded into
// per-layer scroll, palette, priority and disable fields.
module c123_scr_mmr (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rnw,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [63:0] hscr,
    output logic [63:0] vscr,
    output logic [17:0] pal,
    output logic [17:0] prio,
    output logic [5:0]  enb,
    input  logic [4:0]  ioctl_addr,
    output logic [7:0]  ioctl_din,
    input  logic [7:0]  debug_bus,
    output logic [7:0]  st_dout
);

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned NUM_SCROLL = 4;
    localparam int unsigned NUM_LAYERS = 6;
    localparam int unsigned PRIO_BASE  = 16;
    localparam int unsigned PAL_BASE   = 24;

    logic [7:0] regs [NUM_REGS];
    logic       unused_debug_hi;

    // Register array: cleared asynchronously, written by CPU on cs & !rnw
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (cs && !rnw) begin
            regs[addr] <= din;
        end
    end

    assign dout      = regs[addr];
    assign ioctl_din = regs[ioctl_addr];
    assign st_dout   = regs[debug_bus[4:0]];

    // Only the low five selector bits address the array
    assign unused_debug_hi = ^debug_bus[7:5];

    // Scroll values are big-endian pairs: high byte at the lower address
    for (genvar i = 0; i < NUM_SCROLL; i++) begin : g_scroll
        assign hscr[16*i +: 16] = {regs[5'(4*i)],     regs[5'(4*i + 1)]};
        assign vscr[16*i +: 16] = {regs[5'(4*i + 2)], regs[5'(4*i + 3)]};
    end

    for (genvar j = 0; j < NUM_LAYERS; j++) begin : g_layer
        assign prio[3*j +: 3] = regs[5'(PRIO_BASE + j)][2:0];
        assign enb[j]         = regs[5'(PRIO_BASE + j)][3];
        assign pal[3*j +: 3]  = regs[5'(PAL_BASE + j)][2:0];
    end

endmodule

// File: tb/tb_c123_scr_mmr.sv
// Bench for c123_scr_mmr: directed register-map steps plus random CPU
// traffic, checked against a byte-array model of the register file.
module tb_c123_scr_mmr;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [4:0]  addr;
    logic        rnw;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic [63:0] hscr;
    logic [63:0] vscr;
    logic [17:0] pal;
    logic [17:0] prio;
    logic [5:0]  enb;
    logic [4:0]  ioctl_addr;
    logic [7:0]  ioctl_din;
    logic [7:0]  debug_bus;
    logic [7:0]  st_dout;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model [32];

    c123_scr_mmr dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .addr       (addr),
        .rnw        (rnw),
        .din        (din),
        .dout       (dout),
        .hscr       (hscr),
        .vscr       (vscr),
        .pal        (pal),
        .prio       (prio),
        .enb        (enb),
        .ioctl_addr (ioctl_addr),
        .ioctl_din  (ioctl_din),
        .debug_bus  (debug_bus),
        .st_dout    (st_dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_hscr();
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = {model[4*i], model[4*i+1]};
        return r;
    endfunction

    function automatic logic [63:0] exp_vscr();
        logic [63:0] r = '0;
        for (int i = 0; i < 4; i++) r[16*i +: 16] = {model[4*i+2], model[4*i+3]};
        return r;
    endfunction

    function automatic logic [17:0] exp_prio();
        logic [17:0] r = '0;
        for (int j = 0; j < 6; j++) r[3*j +: 3] = model[16+j][2:0];
        return r;
    endfunction

    function automatic logic [5:0] exp_enb();
        logic [5:0] r = '0;
        for (int j = 0; j < 6; j++) r[j] = model[16+j][3];
        return r;
    endfunction

    function automatic logic [17:0] exp_pal();
        logic [17:0] r = '0;
        for (int j = 0; j < 6; j++) r[3*j +: 3] = model[24+j][2:0];
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 32; k++) model[k] = 8'h00;
    endtask

    // Compare every output against the model, probing dump/debug ports at ia/db
    task automatic check_all(input logic [4:0] ia, input logic [7:0] db);
        ioctl_addr = ia;
        debug_bus  = db;
        #1;
        check("hscr", hscr, exp_hscr());
        check("vscr", vscr, exp_vscr());
        check("prio", 64'(prio), 64'(exp_prio()));
        check("enb", 64'(enb), 64'(exp_enb()));
        check("pal", 64'(pal), 64'(exp_pal()));
        check("dout", 64'(dout), 64'(model[addr]));
        check("ioctl_din", 64'(ioctl_din), 64'(model[ia]));
        check("st_dout", 64'(st_dout), 64'(model[db[4:0]]));
    endtask

    // One bus cycle: drive after negedge, check read-before-write, clock, check
    task automatic bus_cycle(input logic c, input logic r, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = c; rnw = r; addr = a; din = d;
        #1;
        check("dout_pre_edge", 64'(dout), 64'(model[a]));
        @(posedge clk);
        if (rst && c && !r) model[a] = d;
        #1;
        check_all(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1'b0; cs = 1'b0; rnw = 1'b1; addr = '0; din = '0;
        ioctl_addr = '0; debug_bus = '0;
        model_clear();

        // Reset held, then released: everything reads zero
        repeat (3) @(posedge clk);
        #1 check_all(5'd7, 8'hE3);
        @(negedge clk);
        rst = 1'b1;
        #1 check_all(5'd31, 8'h1F);
        for (int k = 0; k < 32; k++) begin
            addr = 5'(k);
            #1 check("reset_read", 64'(dout), 64'h00);
        end

        // Register-map directed steps
        bus_cycle(1'b1, 1'b0, 5'h04, 8'h12);
        bus_cycle(1'b1, 1'b0, 5'h05, 8'h34);
        check("hscr1", hscr, 64'h0000_0000_1234_0000);
        addr = 5'h04;
        #1 check("dout04", 64'(dout), 64'h12);
        bus_cycle(1'b1, 1'b0, 5'h0E, 8'hFE);
        bus_cycle(1'b1, 1'b0, 5'h0F, 8'hDC);
        check("vscr3", 64'(vscr[63:48]), 64'hFEDC);
        bus_cycle(1'b1, 1'b0, 5'h12, 8'h0D);
        check("prio2", 64'(prio[8:6]), 64'd5);
        check("enb_only2", 64'(enb), 64'b000100);
        bus_cycle(1'b1, 1'b0, 5'h1D, 8'hFF);
        check("pal5", 64'(pal[17:15]), 64'd7);
        check("pal_others", 64'(pal[14:0]), 64'd0);
        bus_cycle(1'b1, 1'b0, 5'h1F, 8'hA5);
        check_all(5'h1F, 8'hFF);
        check("ioctl_1f", 64'(ioctl_din), 64'hA5);
        check("st_1f", 64'(st_dout), 64'hA5);
        bus_cycle(1'b0, 1'b0, 5'h00, 8'h77);
        bus_cycle(1'b1, 1'b1, 5'h00, 8'h77);
        check("hscr0_blocked", 64'(hscr[15:0]), 64'h0000);

        // Random CPU traffic
        for (int n = 0; n < 400; n++) begin
            bus_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                      5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(negedge clk);
        #2 rst = 1'b0;
        model_clear();
        #1;
        check("async_hscr", hscr, 64'h0);
        check("async_vscr", vscr, 64'h0);
        check_all(5'd3, 8'h72);

        // Write attempted while reset is held is discarded
        bus_cycle(1'b1, 1'b0, 5'h08, 8'h5A);
        check("write_in_reset", 64'(hscr[47:32]), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        cs = 1'b0;
        #1 check_all(5'h08, 8'h08);
        bus_cycle(1'b1, 1'b0, 5'h08, 8'h5A);
        check("post_reset_write", 64'(hscr[47:40]), 64'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
